// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0020;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries; flush wins over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output logic                           head_valid,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers
// responses in order and discards stale ones after a redirect.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = 8;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] req_addr;
  logic            req_pending;
  logic            req_stale;
  logic [CW-1:0]   outstanding;
  logic [DW-1:0]   drop;
  logic [CW-1:0]   buf_count;
  logic            buf_valid;
  fetch_entry_t    buf_head;
  logic [DW-1:0]   credit_used;
  logic            pop, push, issue, accept, accept_live, resp_stale, resp_live;

  // A head leaving this cycle frees its slot before any new response can land.
  assign pop         = buf_valid & instr_ready;
  assign credit_used = DW'(outstanding) + DW'(buf_count) - DW'(pop);
  assign issue       = reset & ~req_pending & ~fault & ~redirect_valid &
                       (credit_used < DW'(DEPTH));

  assign imem_req_valid = req_pending | issue;
  assign imem_req_addr  = req_pending ? req_addr : fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign accept_live    = accept & ~(req_pending & req_stale);
  assign resp_stale     = imem_resp_valid & (drop != '0);
  assign resp_live      = imem_resp_valid & (drop == '0) & (outstanding != '0);
  assign push           = resp_live & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      req_addr    <= RESET_PC;
      req_pending <= 1'b0;
      req_stale   <= 1'b0;
      outstanding <= '0;
      drop        <= '0;
      fault       <= 1'b0;
    end else begin
      if (accept) begin
        req_pending <= 1'b0;
      end else if (issue) begin
        req_pending <= 1'b1;
        req_addr    <= fetch_pc;
        req_stale   <= 1'b0;
      end
      if (redirect_valid) begin
        // Every live in-flight fetch becomes stale; a response arriving now is already gone.
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        outstanding <= '0;
        drop        <= drop + DW'(outstanding) + DW'(req_pending & ~req_stale)
                       - DW'(resp_stale | resp_live);
        if (req_pending & ~accept) req_stale <= 1'b1;
        if (is_misaligned(redirect_pc)) fault <= 1'b1;
      end else begin
        if (accept_live) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        outstanding <= outstanding + CW'(accept_live) - CW'(resp_live);
        if (resp_stale) drop <= drop - 1'b1;
      end
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{pc: resp_pc, instr: imem_resp_data}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (buf_valid),
    .head       (buf_head),
    .count      (buf_count)
  );

  assign instr_valid = buf_valid;
  assign instr       = buf_head.instr;
  assign instr_pc    = buf_head.pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model returning data = address,
// and a scoreboard of the expected consumed PC stream.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        fault;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(BASE), .DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fault           (fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] hs_log[$];
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int          hs_count = 0, req_count = 0, reqv_count = 0;
  logic [31:0] exp_pc = BASE;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        s_ivalid, s_fault, s_reqv, s_resp;
  logic [31:0] s_ipc, s_instr, s_raddr;

  // One clock: drive inputs, let the memory answer, sample, update the models.
  task automatic step(input logic rst_n, input logic rdy, input logic mrdy,
                      input logic redir, input logic [31:0] rpc);
    int due;
    @(posedge clk);
    #1;
    cyc++;
    reset          = rst_n;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (!rst_n) begin
      mq.delete();
      last_due = cyc;
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_ivalid = instr_valid;
    s_ipc    = instr_pc;
    s_instr  = instr;
    s_fault  = fault;
    s_reqv   = imem_req_valid;
    s_raddr  = imem_req_addr;
    s_resp   = imem_resp_valid;
    if (!rst_n) begin
      exp_pc    = BASE;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("req_hold_valid", 32'(imem_req_valid), 32'd1);
        check("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, exp_pc);
        hs_log.push_back(instr_pc);
        hs_count++;
        exp_pc += 32'd4;
      end
      if (redir) exp_pc = rpc;
      if (imem_resp_valid) void'(mq.pop_front());
      if (imem_req_valid) reqv_count++;
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: imem_req_addr, due: due});
        req_count++;
      end
      prev_hold = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    int hs_before;
    logic [31:0] rpc;

    // Reset values
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_req_valid", 32'(s_reqv), 32'd0);
    check("rst_req_addr", s_raddr, BASE);
    check("rst_instr_valid", 32'(s_ivalid), 32'd0);
    check("rst_instr", s_instr, 32'd0);
    check("rst_instr_pc", s_ipc, 32'd0);
    check("rst_fault", 32'(s_fault), 32'd0);

    // Back-to-back stream with a one-cycle memory
    lat_min = 1; lat_max = 1;
    hs_count = 0; hs_log.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t1_rate", 32'(hs_count), 32'd10);
    check("t1_first", (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, BASE);

    // Core stalls: credit allows only two fetches
    do_reset();
    req_count = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("t2_reqs", 32'(req_count), 32'd2);
    check("t2_valid", 32'(s_ivalid), 32'd1);
    check("t2_head", s_ipc, BASE);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t2_next", s_ipc, BASE + 32'd4);

    // Redirect with two slow fetches in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100);
    hs_log.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t3_first", (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, 32'h0040_0100);

    // Redirect coinciding with a response and a consumed head
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0200);
    check("t4_setup", {30'd0, s_ivalid, s_resp}, 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t4_empty", 32'(s_ivalid), 32'd0);
    hs_log.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t4_first", (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, 32'h0040_0200);

    // Misaligned redirect: sticky fault, fetch halts until reset
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0102);
    reqv_count = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t5_fault", 32'(s_fault), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t5_noreq", 32'(reqv_count), 32'd0);
    check("t5_novalid", 32'(s_ivalid), 32'd0);
    do_reset();
    check("t5_clear", 32'(s_fault), 32'd0);

    // Reset with two fetches outstanding
    do_reset();
    lat_min = 4; lat_max = 4;
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t6_valid", 32'(s_ivalid), 32'd0);
    check("t6_req", 32'(s_reqv), 32'd1);
    check("t6_addr", s_raddr, BASE);
    hs_log.delete();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t6_first", (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, BASE);

    // Address wrap at the top of memory
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    hs_log.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t7_wrap", (hs_log.size() > 2) ? hs_log[2] : 32'hFFFF_FFFF, 32'h0000_0000);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    hs_before = hs_count;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) rpc = BASE + ($urandom_range(0, 255) << 2);
      else rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, rpc);
    end
    check("rand_progress", 32'(hs_count - hs_before > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
